// File: rtl/vip_frame_buf_arbiter_if.sv
// rtl/vip_frame_buf_arbiter_if.sv - requester, reader and shared-memory signals of the frame buffer arbiter
interface vip_frame_buf_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int PIX_W  = 19
);
    logic              frame_start;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en;
    logic              mem_we;
    logic [PIX_W:0]    mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_bank;
    logic              busy;

    modport slave (
        input  frame_start, wr_req, wr_data, rd_req, mem_rdata,
        output wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, wr_bank, busy
    );

    modport master (
        output frame_start, wr_req, wr_data, rd_req, mem_rdata,
        input  wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, wr_bank, busy
    );
endinterface

// File: rtl/vip_frame_buf_arbiter.sv
// rtl/vip_frame_buf_arbiter.sv - ping-pong frame buffer arbiter granting write/read bursts on one single-port memory
module vip_frame_buf_arbiter #(
    parameter int DATA_W       = 8,
    parameter int PIX_W        = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int BURST_LEN    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vip_frame_buf_arbiter_if.slave  bus
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;

    state_e            state_q;
    logic [BW-1:0]     beat_q;
    logic [PIX_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PIX_W-1:0]  wr_ptr_d, rd_ptr_d;
    logic              wr_bank_q, pend_q, last_wr_q;
    logic              mem_en_q, mem_we_q, wr_ack_q, busy_q, rd_valid_q;
    logic [PIX_W:0]    mem_addr_q;
    logic [DATA_W-1:0] wdata_hold_q;
    logic              grant_wr, grant_rd, last_beat;

    always_comb begin
        wr_ptr_d  = (wr_ptr_q == PIX_W'(FRAME_PIXELS - 1)) ? '0 : wr_ptr_q + PIX_W'(1);
        rd_ptr_d  = (rd_ptr_q == PIX_W'(FRAME_PIXELS - 1)) ? '0 : rd_ptr_q + PIX_W'(1);
        // On a tie the side not served last wins; last_wr_q resets to "read" so write wins first.
        grant_wr  = bus.wr_req & (~bus.rd_req | ~last_wr_q);
        grant_rd  = bus.rd_req & (~bus.wr_req | last_wr_q);
        last_beat = (beat_q == BW'(BURST_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_bank_q    <= 1'b0;
            pend_q       <= 1'b0;
            last_wr_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            mem_addr_q   <= '0;
            wdata_hold_q <= '0;
        end else begin
            rd_valid_q <= (state_q == RD_BURST);
            case (state_q)
                IDLE: begin
                    if (pend_q || bus.frame_start) begin
                        pend_q    <= 1'b0;
                        wr_bank_q <= ~wr_bank_q;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                    end else if (grant_wr || grant_rd) begin
                        state_q    <= grant_wr ? WR_BURST : RD_BURST;
                        last_wr_q  <= grant_wr;
                        beat_q     <= '0;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= grant_wr;
                        wr_ack_q   <= grant_wr;
                        busy_q     <= 1'b1;
                        mem_addr_q <= grant_wr ? {wr_bank_q, wr_ptr_q} : {~wr_bank_q, rd_ptr_q};
                    end
                end
                WR_BURST, RD_BURST: begin
                    if (bus.frame_start) pend_q <= 1'b1;
                    if (state_q == WR_BURST) begin
                        wr_ptr_q     <= wr_ptr_d;
                        wdata_hold_q <= bus.wr_data;
                    end else begin
                        rd_ptr_q <= rd_ptr_d;
                    end
                    if (last_beat) begin
                        state_q  <= IDLE;
                        beat_q   <= '0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        wr_ack_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        beat_q     <= beat_q + BW'(1);
                        mem_addr_q <= {mem_addr_q[PIX_W], (state_q == WR_BURST) ? wr_ptr_d : rd_ptr_d};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data comes straight from the FWFT head so it stays aligned with the same-cycle pop.
    assign bus.mem_wdata = (state_q == WR_BURST) ? bus.wr_data : wdata_hold_q;
    assign bus.rd_data   = rd_valid_q ? bus.mem_rdata : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.wr_bank   = wr_bank_q;
endmodule
